rocc_fu_sequencer: RTL

Sequences RoCC commands into the shared HLS stream functional unit and turns its output beats back into RoCC responses. Tracks outstanding commands in a tag FIFO and caps them at `MAX_INFLIGHT`. Suppresses responses for commands with `xd=0`, implements a fence command, and derives the accelerator busy flag. Sits between the RoCC command/response ports and the FU's `IN_r`/`OUT_r` streams inside the accelerator top.

---
 rtl/rocc_fu_sequencer_if.sv | 35 +++
 rtl/rocc_fu_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rocc_fu_sequencer_if.sv
// Bundle of the RoCC command/response ports and the FU IN_r/OUT_r streams.
// Every pair is valid/ready: a beat transfers on a rising clock edge where both are high, and the sender holds its payload steady while valid is high and ready is low.
interface rocc_fu_sequencer_if #(
    parameter int XLEN = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [31:0]           cmd_inst;
    logic [XLEN-1:0]       cmd_rs1;
    logic [XLEN-1:0]       cmd_rs2;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [4:0]            resp_rd;
    logic [XLEN-1:0]       resp_data;
    logic                  fu_in_valid;
    logic                  fu_in_ready;
    logic [2*XLEN+31:0]    fu_in_data;
    logic                  fu_out_valid;
    logic                  fu_out_ready;
    logic [XLEN+7:0]       fu_out_data;

    modport master (
        input  cmd_valid, cmd_inst, cmd_rs1, cmd_rs2, resp_ready,
        input  fu_in_ready, fu_out_valid, fu_out_data,
        output cmd_ready, resp_valid, resp_rd, resp_data,
        output fu_in_valid, fu_in_data, fu_out_ready
    );

    modport slave (
        output cmd_valid, cmd_inst, cmd_rs1, cmd_rs2, resp_ready,
        output fu_in_ready, fu_out_valid, fu_out_data,
        input  cmd_ready, resp_valid, resp_rd, resp_data,
        input  fu_in_valid, fu_in_data, fu_out_ready
    );
endinterface

// File: rtl/rocc_fu_sequencer.sv
// Forwards RoCC commands to the HLS stream FU, tracks outstanding {xd, rd} tags,
// turns FU output beats into RoCC responses, and implements the fence command.
module rocc_fu_sequencer #(
    parameter int         XLEN         = 64,
    parameter int         MAX_INFLIGHT = 4,
    parameter logic [6:0] FENCE_FUNCT  = 7'h7F
) (
    input  logic                clock,
    input  logic                reset,
    rocc_fu_sequencer_if.master bus,
    output logic                busy,
    output logic                err_mismatch,
    output logic                err_unexpected,
    output logic                dbg_state
);
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_INFLIGHT);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FENCE = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [5:0]      tag_q [MAX_INFLIGHT];
    logic [5:0]      tag_d [MAX_INFLIGHT];
    logic            resp_valid_q, resp_valid_d;
    logic [4:0]      resp_rd_q, resp_rd_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic            fence_xd_q, fence_xd_d;
    logic [4:0]      fence_rd_q, fence_rd_d;
    logic            err_mismatch_q, err_mismatch_d;
    logic            err_unexpected_q, err_unexpected_d;

    logic       is_fence, not_full, push, out_fire, pop, resp_fire, slot_free;
    logic       fence_accept, fence_done, fence_xd_now;
    logic [4:0] fence_rd_now;
    logic [5:0] head;
    logic       unused_fu_bits;

    assign is_fence     = (bus.cmd_inst[31:25] == FENCE_FUNCT);
    assign not_full     = (count_q < FULL);
    assign push         = bus.fu_in_valid & bus.fu_in_ready;
    assign out_fire     = bus.fu_out_valid & bus.fu_out_ready;
    assign pop          = out_fire & (count_q != '0);
    assign resp_fire    = resp_valid_q & bus.resp_ready;
    assign slot_free    = ~resp_valid_q | bus.resp_ready;
    assign fence_accept = (state_q == ST_RUN) & bus.cmd_valid & is_fence;
    assign head         = tag_q[rptr_q];
    assign unused_fu_bits = ^bus.fu_out_data[7:5];

    // A fence accepted while idle completes in its accept cycle, so the xd/rd
    // come straight from the instruction rather than from the latched copy.
    assign fence_xd_now = (state_q == ST_RUN) ? bus.cmd_inst[14]   : fence_xd_q;
    assign fence_rd_now = (state_q == ST_RUN) ? bus.cmd_inst[11:7] : fence_rd_q;

    assign bus.fu_in_data   = {bus.cmd_rs2, bus.cmd_rs1, bus.cmd_inst};
    assign bus.fu_out_ready = ~resp_valid_q | bus.resp_ready;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rd      = resp_rd_q;
    assign bus.resp_data    = resp_data_q;

    assign busy           = (count_q != '0) | resp_valid_q | (state_q == ST_FENCE);
    assign err_mismatch   = err_mismatch_q;
    assign err_unexpected = err_unexpected_q;
    assign dbg_state      = (state_q == ST_FENCE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_RUN;
            count_q          <= '0;
            wptr_q           <= '0;
            rptr_q           <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) tag_q[i] <= '0;
            resp_valid_q     <= 1'b0;
            resp_rd_q        <= '0;
            resp_data_q      <= '0;
            fence_xd_q       <= 1'b0;
            fence_rd_q       <= '0;
            err_mismatch_q   <= 1'b0;
            err_unexpected_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            wptr_q           <= wptr_d;
            rptr_q           <= rptr_d;
            tag_q            <= tag_d;
            resp_valid_q     <= resp_valid_d;
            resp_rd_q        <= resp_rd_d;
            resp_data_q      <= resp_data_d;
            fence_xd_q       <= fence_xd_d;
            fence_rd_q       <= fence_rd_d;
            err_mismatch_q   <= err_mismatch_d;
            err_unexpected_q <= err_unexpected_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fence_done = 1'b0;
        if (state_q == ST_RUN) begin
            if (fence_accept) begin
                if ((count_q == '0) && slot_free) fence_done = 1'b1;
                else                              state_d    = ST_FENCE;
            end
        end else begin
            if ((count_q == '0) && slot_free) begin
                fence_done = 1'b1;
                state_d    = ST_RUN;
            end
        end
    end

    always_comb begin
        bus.cmd_ready   = 1'b0;
        bus.fu_in_valid = 1'b0;
        if (state_q == ST_RUN) begin
            if (is_fence) begin
                bus.cmd_ready = 1'b1;
            end else begin
                bus.cmd_ready   = bus.fu_in_ready & not_full;
                bus.fu_in_valid = bus.cmd_valid & not_full;
            end
        end
    end

    always_comb begin
        tag_d            = tag_q;
        wptr_d           = wptr_q;
        rptr_d           = rptr_q;
        count_d          = count_q;
        resp_valid_d     = resp_valid_q & ~resp_fire;
        resp_rd_d        = resp_rd_q;
        resp_data_d      = resp_data_q;
        fence_xd_d       = fence_xd_q;
        fence_rd_d       = fence_rd_q;
        err_mismatch_d   = err_mismatch_q;
        err_unexpected_d = err_unexpected_q;

        if (push) begin
            tag_d[wptr_q] = {bus.cmd_inst[14], bus.cmd_inst[11:7]};
            wptr_d        = wptr_q + PW'(1);
        end
        // The response carries the tracked rd, not whatever rd the FU echoed.
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
            if (head[5]) begin
                resp_valid_d = 1'b1;
                resp_rd_d    = head[4:0];
                resp_data_d  = bus.fu_out_data[XLEN+7:8];
            end
            if (bus.fu_out_data[4:0] != head[4:0]) err_mismatch_d = 1'b1;
        end
        if (out_fire && (count_q == '0)) err_unexpected_d = 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (fence_accept) begin
            fence_xd_d = bus.cmd_inst[14];
            fence_rd_d = bus.cmd_inst[11:7];
        end
        if (fence_done && fence_xd_now) begin
            resp_valid_d = 1'b1;
            resp_rd_d    = fence_rd_now;
            resp_data_d  = '0;
        end
    end
endmodule
